// File: rtl/nios2_oci_pkg.sv
// Shared definitions for the Nios II OCI memory sequencer.
//   state_t      : sequencer FSM states
//   ocimem_cmd_t : decoded strobe command; the numeric encoding is also the priority order
//   JDO_*        : bit positions of the fields carried in jdo
//   decode_cmd   : priority encoder ocimem_b > ocimem_a > no_action_a
package nios2_oci_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Higher value wins when several strobes arrive together.
    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_RD_CUR = 2'd1,
        CMD_LOAD   = 2'd2,
        CMD_WR     = 2'd3
    } ocimem_cmd_t;

    localparam int JDO_RDEN_BIT  = 35;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_ADDR_LSB  = 17;

    function automatic ocimem_cmd_t decode_cmd(input logic strobe_b,
                                               input logic strobe_a,
                                               input logic strobe_na);
        ocimem_cmd_t cmd;
        cmd = CMD_NONE;
        if (strobe_b)
            cmd = CMD_WR;
        else if (strobe_a)
            cmd = CMD_LOAD;
        else if (strobe_na)
            cmd = CMD_RD_CUR;
        return cmd;
    endfunction

endpackage

// File: rtl/nios2_oci_timeout_ctr.sv
// Access watchdog for the OCI memory sequencer.
// Down-counter reloaded while clr is high and decremented while en is high;
// expired is raised during the TIMEOUT_CYC-th enabled cycle after the reload.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : reload the counter
//   en           : count this cycle
//   expired      : terminal count reached while enabled
module nios2_oci_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= LOAD;
        else if (clr)
            cnt <= LOAD;
        else if (en && (cnt != '0))
            cnt <= cnt - CW'(1);
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/nios2_ocimem_sequencer.sv
// Sysclk-side controller for the Nios II JTAG debug OCI memory path.
// Decodes the ocimem strobes and jdo, runs one read or write at a time on a
// req/gnt/rvalid port with address auto-increment, and reports back through
// MonDReg / monitor_ready / monitor_error.
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   take_action_ocimem_a              : load address from jdo, read if jdo[35]
//   take_no_action_ocimem_a           : read at current address
//   take_action_ocimem_b              : write jdo[34:3] at current address
//   jdo                               : JTAG data
//   mem_req/we/addr/wdata             : request side of the debug RAM port
//   mem_gnt/rvalid/rdata              : response side of the debug RAM port
//   MonDReg                           : last read data or echoed write data
//   monitor_ready                     : no command in flight
//   monitor_error                     : last command overran or timed out
// Build option: NIOS2_OCIMEM_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on REQ/WAIT.
//
// state   | meaning
// IDLE    | ready for a command
// REQ     | mem_req held until mem_gnt
// WAIT    | read granted, waiting for mem_rvalid
module nios2_ocimem_sequencer
    import nios2_oci_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    state_t            state;
    ocimem_cmd_t       cmd;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] jdo_addr;
    logic [DATA_W-1:0] jdo_wdata;
    logic              any_strobe;
    logic              timeout_hit;
    logic [4:0]        unused_jdo;

    assign cmd        = decode_cmd(take_action_ocimem_b, take_action_ocimem_a,
                                   take_no_action_ocimem_a);
    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata  = jdo[JDO_WDATA_LSB +: DATA_W];
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign unused_jdo = {jdo[37:36], jdo[2:0]};

`ifdef NIOS2_OCIMEM_TIMEOUT_EN
    // Reloading throughout IDLE is equivalent to clearing on accept.
    nios2_oci_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state == ST_IDLE),
        .en      (state != ST_IDLE),
        .expired (timeout_hit)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            addr          <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    case (cmd)
                        CMD_WR: begin
                            mem_req       <= 1'b1;
                            mem_we        <= 1'b1;
                            mem_addr      <= addr;
                            mem_wdata     <= jdo_wdata;
                            MonDReg       <= jdo_wdata;
                            monitor_ready <= 1'b0;
                            monitor_error <= 1'b0;
                            state         <= ST_REQ;
                        end
                        CMD_LOAD: begin
                            addr <= jdo_addr;
                            if (jdo[JDO_RDEN_BIT]) begin
                                mem_req       <= 1'b1;
                                mem_we        <= 1'b0;
                                mem_addr      <= jdo_addr;
                                monitor_ready <= 1'b0;
                                monitor_error <= 1'b0;
                                state         <= ST_REQ;
                            end
                        end
                        CMD_RD_CUR: begin
                            mem_req       <= 1'b1;
                            mem_we        <= 1'b0;
                            mem_addr      <= addr;
                            monitor_ready <= 1'b0;
                            monitor_error <= 1'b0;
                            state         <= ST_REQ;
                        end
                        default: ;
                    endcase
                end
                ST_REQ: begin
                    if (any_strobe)
                        monitor_error <= 1'b1;
                    // A completed handshake takes precedence over a coincident timeout.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        addr    <= addr + ADDR_W'(1);
                        if (mem_we) begin
                            monitor_ready <= 1'b1;
                            state         <= ST_IDLE;
                        end else if (mem_rvalid) begin
                            MonDReg       <= mem_rdata;
                            monitor_ready <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else if (timeout_hit) begin
                        mem_req       <= 1'b0;
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (any_strobe)
                        monitor_error <= 1'b1;
                    if (mem_rvalid) begin
                        MonDReg       <= mem_rdata;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (timeout_hit) begin
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_ocimem_sequencer.sv
// Directed bench for nios2_ocimem_sequencer (ADDR_W=10, TIMEOUT_CYC=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_nios2_ocimem_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [37:0] jdo = '0;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int n_cmp = 0;
    int n_err = 0;
    int hs_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (reset_n && mem_req && mem_gnt)
            hs_count <= hs_count + 1;

    nios2_ocimem_sequencer #(
        .ADDR_W      (10),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .mem_req                 (mem_req),
        .mem_we                  (mem_we),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_gnt                 (mem_gnt),
        .mem_rvalid              (mem_rvalid),
        .mem_rdata               (mem_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // Stimulus helpers; each is entered and left on a falling edge.
    task automatic cmd_a(input logic [9:0] a, input logic rden);
        jdo = '0;
        jdo[26:17] = a;
        jdo[35] = rden;
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        jdo = '0;
    endtask

    task automatic cmd_na();
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic cmd_b(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        jdo = '0;
    endtask

    task automatic grant(input logic rv, input logic [31:0] rd);
        mem_gnt = 1'b1;
        mem_rvalid = rv;
        mem_rdata = rd;
        @(negedge clk);
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic rvalid_pulse(input logic [31:0] rd);
        mem_rvalid = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 10'h000) begin n_err++; $display("FAIL rst_addr: got %h want 000", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (MonDReg !== 32'h0) begin n_err++; $display("FAIL rst_mondreg: got %h want 0", MonDReg); end
        n_cmp++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", monitor_ready); end
        n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL rst_error: got %b want 0", monitor_error); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        cmd_a(10'h010, 1'b1);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rd_req: got %b want 1", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rd_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 10'h010) begin n_err++; $display("FAIL rd_addr: got %h want 010", mem_addr); end
        n_cmp++; if (monitor_ready !== 1'b0) begin n_err++; $display("FAIL rd_busy: got %b want 0", monitor_ready); end
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rd_req_hold: got %b want 1", mem_req); end
        grant(1'b0, 32'h0);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rd_req_drop: got %b want 0", mem_req); end
        n_cmp++; if (monitor_ready !== 1'b0) begin n_err++; $display("FAIL rd_wait_busy: got %b want 0", monitor_ready); end
        rvalid_pulse(32'hDEADBEEF);
        n_cmp++; if (MonDReg !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", MonDReg); end
        n_cmp++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready: got %b want 1", monitor_ready); end
        n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL rd_error: got %b want 0", monitor_error); end
        // Auto-increment plus gnt and rvalid arriving together.
        cmd_na();
        n_cmp++; if (mem_addr !== 10'h011) begin n_err++; $display("FAIL rd_incr: got %h want 011", mem_addr); end
        grant(1'b1, 32'h12345678);
        n_cmp++; if (MonDReg !== 32'h12345678) begin n_err++; $display("FAIL rd_same_cycle: got %h want 12345678", MonDReg); end
        n_cmp++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL rd_same_ready: got %b want 1", monitor_ready); end
    endtask

    task automatic test_write_wrap();
        logic [9:0] exp_addr [3];
        exp_addr[0] = 10'h3FF;
        exp_addr[1] = 10'h000;
        exp_addr[2] = 10'h001;
        cmd_a(10'h3FF, 1'b0);
        n_cmp++; if (mem_req !== 1'b0 || monitor_ready !== 1'b1) begin
            n_err++; $display("FAIL wr_load_only: req %b ready %b want 0 1", mem_req, monitor_ready); end
        for (int i = 0; i < 3; i++) begin
            cmd_b(32'(i + 1));
            n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
                n_err++; $display("FAIL wr_req%0d: req %b we %b want 1 1", i, mem_req, mem_we); end
            n_cmp++; if (mem_addr !== exp_addr[i]) begin
                n_err++; $display("FAIL wr_addr%0d: got %h want %h", i, mem_addr, exp_addr[i]); end
            n_cmp++; if (mem_wdata !== 32'(i + 1)) begin
                n_err++; $display("FAIL wr_wdata%0d: got %h want %h", i, mem_wdata, 32'(i + 1)); end
            grant(1'b0, 32'h0);
            n_cmp++; if (monitor_ready !== 1'b1 || mem_req !== 1'b0) begin
                n_err++; $display("FAIL wr_done%0d: ready %b req %b want 1 0", i, monitor_ready, mem_req); end
        end
        n_cmp++; if (MonDReg !== 32'h3) begin n_err++; $display("FAIL wr_mondreg: got %h want 3", MonDReg); end
        n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL wr_error: got %b want 0", monitor_error); end
    endtask

    task automatic test_overrun();
        int base;
        base = hs_count;
        cmd_na();
        n_cmp++; if (mem_addr !== 10'h002) begin n_err++; $display("FAIL ovr_addr: got %h want 002", mem_addr); end
        cmd_na();
        n_cmp++; if (monitor_error !== 1'b1) begin n_err++; $display("FAIL ovr_error_set: got %b want 1", monitor_error); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 10'h002) begin
            n_err++; $display("FAIL ovr_req_kept: req %b addr %h want 1 002", mem_req, mem_addr); end
        grant(1'b0, 32'h0);
        rvalid_pulse(32'hCAFE0001);
        n_cmp++; if (MonDReg !== 32'hCAFE0001 || monitor_ready !== 1'b1) begin
            n_err++; $display("FAIL ovr_complete: data %h ready %b want cafe0001 1", MonDReg, monitor_ready); end
        n_cmp++; if (monitor_error !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", monitor_error); end
        n_cmp++; if (hs_count - base !== 1) begin n_err++; $display("FAIL ovr_single: got %0d want 1", hs_count - base); end
        cmd_b(32'h000000A5);
        n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", monitor_error); end
        n_cmp++; if (mem_addr !== 10'h003) begin n_err++; $display("FAIL ovr_next_addr: got %h want 003", mem_addr); end
        grant(1'b0, 32'h0);
    endtask

    task automatic test_priority();
        jdo = {2'b00, 1'b1, 32'h00554000, 3'b000};
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        jdo = '0;
        n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL pri_we: got %b want 1", mem_we); end
        n_cmp++; if (mem_addr !== 10'h004) begin n_err++; $display("FAIL pri_addr: got %h want 004", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h00554000) begin n_err++; $display("FAIL pri_wdata: got %h want 00554000", mem_wdata); end
        n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL pri_error: got %b want 0", monitor_error); end
        grant(1'b0, 32'h0);
        cmd_na();
        n_cmp++; if (mem_addr !== 10'h005) begin n_err++; $display("FAIL pri_no_reload: got %h want 005", mem_addr); end
        grant(1'b1, 32'h5A5A5A5A);
    endtask

    task automatic test_reset_mid_access();
        cmd_na();
        grant(1'b0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 10'h000) begin
            n_err++; $display("FAIL mrst_req: req %b addr %h want 0 000", mem_req, mem_addr); end
        n_cmp++; if (MonDReg !== 32'h0) begin n_err++; $display("FAIL mrst_mondreg: got %h want 0", MonDReg); end
        n_cmp++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin
            n_err++; $display("FAIL mrst_status: ready %b error %b want 1 0", monitor_ready, monitor_error); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rvalid_pulse(32'h00000BAD);
        n_cmp++; if (MonDReg !== 32'h0 || monitor_ready !== 1'b1) begin
            n_err++; $display("FAIL mrst_stray_rvalid: data %h ready %b want 0 1", MonDReg, monitor_ready); end
        cmd_na();
        n_cmp++; if (mem_addr !== 10'h000 || mem_req !== 1'b1) begin
            n_err++; $display("FAIL mrst_addr: addr %h req %b want 000 1", mem_addr, mem_req); end
        grant(1'b1, 32'h11110000);
    endtask

    task automatic test_timeout();
        cmd_na();
        n_cmp++; if (mem_addr !== 10'h001) begin n_err++; $display("FAIL to_addr: got %h want 001", mem_addr); end
`ifdef NIOS2_OCIMEM_TIMEOUT_EN
        repeat (7) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL to_req_cycle8: got %b want 1", mem_req); end
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL to_req_drop: got %b want 0", mem_req); end
        n_cmp++; if (monitor_error !== 1'b1 || monitor_ready !== 1'b1) begin
            n_err++; $display("FAIL to_status: error %b ready %b want 1 1", monitor_error, monitor_ready); end
        rvalid_pulse(32'hFFFF0000);
        n_cmp++; if (MonDReg !== 32'h11110000) begin n_err++; $display("FAIL to_late_rvalid: got %h want 11110000", MonDReg); end
        cmd_na();
        n_cmp++; if (mem_addr !== 10'h001) begin n_err++; $display("FAIL to_addr_kept: got %h want 001", mem_addr); end
        grant(1'b1, 32'h0);
`else
        repeat (40) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || monitor_ready !== 1'b0) begin
            n_err++; $display("FAIL nto_hold: req %b ready %b want 1 0", mem_req, monitor_ready); end
        grant(1'b1, 32'h77770000);
        n_cmp++; if (MonDReg !== 32'h77770000 || monitor_error !== 1'b0) begin
            n_err++; $display("FAIL nto_complete: data %h error %b want 77770000 0", MonDReg, monitor_error); end
`endif
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wrap();
        test_overrun();
        test_priority();
        test_reset_mid_access();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
